// File: rtl/flag_hazard_ctrl_if.sv
// Decode / execute / condition-evaluation signal bundle for flag_hazard_ctrl.
// CW must match the CW of the flag_hazard_ctrl instance the bundle connects to.
interface flag_hazard_ctrl_if #(
    parameter int CW = 3
);
    logic          dec_valid;
    logic          dec_reads_flags;
    logic          dec_sets_flags;
    logic          dec_stall;
    logic          ex_retire;
    logic          ex_flag_we;
    logic [3:0]    ex_flags;
    logic          msr_we;
    logic [3:0]    msr_flags;
    logic          flush;
    logic [31:0]   cpsr;
    logic [CW-1:0] pending;
    logic          proto_err;

    // Pipeline side: drives decode/execute information, observes stall and flags
    modport master (
        output dec_valid, dec_reads_flags, dec_sets_flags,
        output ex_retire, ex_flag_we, ex_flags, msr_we, msr_flags, flush,
        input  dec_stall, cpsr, pending, proto_err
    );

    // Flag controller side
    modport slave (
        input  dec_valid, dec_reads_flags, dec_sets_flags,
        input  ex_retire, ex_flag_we, ex_flags, msr_we, msr_flags, flush,
        output dec_stall, cpsr, pending, proto_err
    );
endinterface

// File: rtl/flag_hazard_ctrl.sv
// NZCV flag owner and flag-hazard scheduler between decode and execute.
// Tracks in-flight flag setters, stalls readers of stale flags, and bypasses
// retiring flag writes straight to the condition evaluator.
module flag_hazard_ctrl #(
    parameter int PEND_MAX = 3,
    parameter int CW       = 3
) (
    input  logic             clk,
    input  logic             rst,
    flag_hazard_ctrl_if.slave bus
);

    localparam logic [CW-1:0] L_PEND_MAX = CW'(PEND_MAX);

    // Occupancy classes of the in-flight setter counter
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic state_t classify(input logic [CW-1:0] cnt);
        if (cnt == '0)
            return ST_EMPTY;
        else if (cnt == L_PEND_MAX)
            return ST_FULL;
        else
            return ST_BUSY;
    endfunction

    logic [3:0]    r_flags;
    logic [CW-1:0] r_pending;
    logic          r_proto_err;

    state_t        w_state;
    state_t        w_eff_state;
    logic          w_ret_cnt;
    logic [CW-1:0] w_pend_eff;
    logic [CW-1:0] w_pend_next;
    logic          w_wr;
    logic [3:0]    w_next_flags;
    logic          w_rd_haz;
    logic          w_full_haz;
    logic          w_stall;
    logic          w_issue_set;

    // Flag write-back selection; MSR takes precedence over the ALU result
    always_comb begin
        w_wr         = bus.ex_retire & (bus.msr_we | bus.ex_flag_we);
        w_next_flags = r_flags;
        if (bus.ex_retire) begin
            if (bus.msr_we)
                w_next_flags = bus.msr_flags;
            else if (bus.ex_flag_we)
                w_next_flags = bus.ex_flags;
        end
    end

    // Architectural flags register; a stray retire at pending==0 still writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_flags <= 4'd0;
        else if (w_wr)
            r_flags <= w_next_flags;
    end

    // Counter FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pending <= '0;
        else
            r_pending <= w_pend_next;
    end

    // Counter FSM: next state; a retire this cycle frees a slot before issue is judged
    always_comb begin
        w_state     = classify(r_pending);
        w_ret_cnt   = bus.ex_retire & (w_state != ST_EMPTY);
        w_pend_eff  = r_pending - CW'(w_ret_cnt);
        w_eff_state = classify(w_pend_eff);
        w_issue_set = bus.dec_valid & ~w_stall & bus.dec_sets_flags;
        if (bus.flush)
            w_pend_next = '0;
        else
            w_pend_next = w_pend_eff + CW'(w_issue_set);
    end

    // Counter FSM: outputs; flush wins so the branch target fetch is never held
    always_comb begin
        w_rd_haz   = bus.dec_reads_flags & (w_eff_state != ST_EMPTY);
        w_full_haz = bus.dec_sets_flags  & (w_eff_state == ST_FULL);
        w_stall    = bus.dec_valid & ~bus.flush & (w_rd_haz | w_full_haz);
    end

    // Sticky protocol error: a retire with no counted setter outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_proto_err <= 1'b0;
        else if (bus.ex_retire && (w_state == ST_EMPTY))
            r_proto_err <= 1'b1;
    end

    assign bus.dec_stall = w_stall;
    assign bus.cpsr      = {(w_wr ? w_next_flags : r_flags), 28'd0};
    assign bus.pending   = r_pending;
    assign bus.proto_err = r_proto_err;

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// Self-checking bench for flag_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_flag_hazard_ctrl;

    localparam int PEND_MAX = 3;
    localparam int CW       = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int       m_pend  = 0;
    bit [3:0] m_flags = 4'd0;
    bit       m_err   = 1'b0;

    flag_hazard_ctrl_if #(.CW(CW)) bus ();

    flag_hazard_ctrl #(.PEND_MAX(PEND_MAX), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic int model_eff();
        return m_pend - ((bus.ex_retire && m_pend != 0) ? 1 : 0);
    endfunction

    function automatic bit model_stall();
        int eff;
        eff = model_eff();
        return bus.dec_valid && !bus.flush &&
               ((bus.dec_reads_flags && eff != 0) || (bus.dec_sets_flags && eff == PEND_MAX));
    endfunction

    function automatic bit model_wr();
        return bus.ex_retire && (bus.msr_we || bus.ex_flag_we);
    endfunction

    function automatic bit [3:0] model_nflags();
        if (!bus.ex_retire)  return m_flags;
        if (bus.msr_we)      return bus.msr_flags;
        if (bus.ex_flag_we)  return bus.ex_flags;
        return m_flags;
    endfunction

    task automatic check_model(input string tag);
        bit [31:0] ecpsr;
        ecpsr = {model_nflags(), 28'd0};
        chk({tag, ".stall"},   {31'd0, bus.dec_stall}, {31'd0, model_stall()});
        chk({tag, ".cpsr"},    bus.cpsr, ecpsr);
        chk({tag, ".pending"}, {{(32-CW){1'b0}}, bus.pending}, m_pend);
        chk({tag, ".perr"},    {31'd0, bus.proto_err}, {31'd0, m_err});
    endtask

    // Apply one cycle of inputs at the falling edge and check combinational/registered outputs
    task automatic drive(input string tag,
                         input bit v, input bit rd, input bit st,
                         input bit ret, input bit fwe, input bit [3:0] exf,
                         input bit msr, input bit [3:0] msrf, input bit fl);
        @(negedge clk);
        bus.dec_valid       = v;
        bus.dec_reads_flags = rd;
        bus.dec_sets_flags  = st;
        bus.ex_retire       = ret;
        bus.ex_flag_we      = fwe;
        bus.ex_flags        = exf;
        bus.msr_we          = msr;
        bus.msr_flags       = msrf;
        bus.flush           = fl;
        #1;
        check_model(tag);
    endtask

    // Advance the model across the rising edge with the inputs currently applied
    task automatic tick();
        int  eff;
        bit  issue_set;
        bit  wr;
        bit [3:0] nf;
        eff       = model_eff();
        issue_set = bus.dec_valid && !model_stall() && bus.dec_sets_flags;
        wr        = model_wr();
        nf        = model_nflags();
        @(posedge clk);
        if (wr) m_flags = nf;
        if (bus.ex_retire && m_pend == 0) m_err = 1'b1;
        m_pend = bus.flush ? 0 : eff + (issue_set ? 1 : 0);
    endtask

    task automatic idle(input string tag);
        drive(tag, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0);
    endtask

    task automatic async_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        m_pend = 0; m_flags = 4'd0; m_err = 1'b0;
        chk({tag, ".stall"},   {31'd0, bus.dec_stall}, 32'd0);
        chk({tag, ".cpsr"},    bus.cpsr, 32'd0);
        chk({tag, ".pending"}, {{(32-CW){1'b0}}, bus.pending}, 32'd0);
        chk({tag, ".perr"},    {31'd0, bus.proto_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.dec_valid = 0; bus.dec_reads_flags = 0; bus.dec_sets_flags = 0;
        bus.ex_retire = 0; bus.ex_flag_we = 0; bus.ex_flags = 0;
        bus.msr_we = 0; bus.msr_flags = 0; bus.flush = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.cpsr",    bus.cpsr, 32'd0);
        chk("rst.pending", {{(32-CW){1'b0}}, bus.pending}, 32'd0);
        chk("rst.perr",    {31'd0, bus.proto_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reader with nothing in flight
        drive("rd0", 1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 0);
        chk("rd0.stall_c", {31'd0, bus.dec_stall}, 32'd0);
        chk("rd0.cpsr_c",  bus.cpsr, 32'h0000_0000);
        tick();

        // Setter, then reader stalls until the setter retires with bypass
        drive("set1", 1, 0, 1, 0, 0, 4'd0, 0, 4'd0, 0); tick();
        drive("rdhaz", 1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 0);
        chk("rdhaz.stall_c", {31'd0, bus.dec_stall}, 32'd1);
        tick();
        drive("rdbyp", 1, 1, 0, 1, 1, 4'b0100, 0, 4'd0, 0);
        chk("rdbyp.stall_c", {31'd0, bus.dec_stall}, 32'd0);
        chk("rdbyp.cpsr_c",  bus.cpsr, 32'h4000_0000);
        tick();
        idle("rdbyp_after");
        chk("rdbyp.pend_c", {{(32-CW){1'b0}}, bus.pending}, 32'd0);
        tick();

        // Fill the tracker, full stall, then issue-with-retire keeps it full
        for (int i = 0; i < 3; i++) begin
            drive("fill", 1, 0, 1, 0, 0, 4'd0, 0, 4'd0, 0); tick();
        end
        drive("full", 1, 0, 1, 0, 0, 4'd0, 0, 4'd0, 0);
        chk("full.pend_c",  {{(32-CW){1'b0}}, bus.pending}, 32'd3);
        chk("full.stall_c", {31'd0, bus.dec_stall}, 32'd1);
        tick();
        drive("fullret", 1, 0, 1, 1, 0, 4'd0, 0, 4'd0, 0);
        chk("fullret.stall_c", {31'd0, bus.dec_stall}, 32'd0);
        tick();
        idle("fullret_after");
        chk("fullret.pend_c", {{(32-CW){1'b0}}, bus.pending}, 32'd3);
        tick();

        // MSR beats ALU write
        drive("msr", 0, 0, 0, 1, 1, 4'b0110, 1, 4'b1001, 0);
        chk("msr.cpsr_c", bus.cpsr, 32'h9000_0000);
        tick();
        idle("msr_after");
        chk("msr.flags_c", bus.cpsr, 32'h9000_0000);
        chk("msr.pend_c",  {{(32-CW){1'b0}}, bus.pending}, 32'd2);
        tick();

        // Flush with an older retire: flags written, counter cleared, no stall
        drive("flush", 1, 1, 1, 1, 1, 4'b0010, 0, 4'd0, 1);
        chk("flush.cpsr_c",  bus.cpsr, 32'h2000_0000);
        chk("flush.stall_c", {31'd0, bus.dec_stall}, 32'd0);
        tick();
        idle("flush_after");
        chk("flush.pend_c", {{(32-CW){1'b0}}, bus.pending}, 32'd0);
        tick();

        // Retire with nothing pending: sticky error, write still applied
        drive("perr", 0, 0, 0, 1, 1, 4'b1111, 0, 4'd0, 0); tick();
        idle("perr1");
        chk("perr1.perr_c", {31'd0, bus.proto_err}, 32'd1);
        chk("perr1.cpsr_c", bus.cpsr, 32'hF000_0000);
        tick();
        drive("perr2", 1, 0, 1, 0, 0, 4'd0, 0, 4'd0, 0); tick();
        idle("perr3");
        chk("perr3.perr_c", {31'd0, bus.proto_err}, 32'd1);

        // Asynchronous reset mid-stream
        async_reset("arst");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit v, rd, st, ret, fwe, msr, fl;
            v   = ($urandom_range(0, 9) < 7);
            rd  = $urandom_range(0, 1);
            st  = ($urandom_range(0, 9) < 6);
            ret = ($urandom_range(0, 9) < ((m_pend != 0) ? 5 : 1));
            fwe = $urandom_range(0, 1);
            msr = ($urandom_range(0, 9) < 2);
            fl  = ($urandom_range(0, 29) == 0);
            drive("rnd", v, rd, st, ret, fwe, 4'($urandom), msr, 4'($urandom), fl);
            tick();
            if (i == 200) async_reset("rnd_arst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: sequence did not complete");
        $fatal(1, "timeout");
    end

endmodule
